// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the horizontal and vertical sync timers:
// state encoding, default VGA-style lengths and the sync polarity helper.
package vga_timing_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PULSE  = 3'd1,
    ST_BACK   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FRONT  = 3'd4
  } timer_state_t;

  localparam int DEF_PULSE_CYCLES  = 384;
  localparam int DEF_BACK_CYCLES   = 192;
  localparam int DEF_ACTIVE_CYCLES = 2560;
  localparam int DEF_FRONT_CYCLES  = 64;
  localparam int DEF_PIXEL_DIV     = 20;

  // Map a logical "sync asserted" onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return active_low ? ~asserted : asserted;
  endfunction

endpackage

// File: rtl/pixel_divider.sv
// Divides advance ticks down to pixels inside ACTIVE and keeps a saturating
// pixel index. Everything clears whenever the timer is not in ACTIVE.
module pixel_divider #(
  parameter int PIXEL_DIV = 20,
  parameter int PIX_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             advance,
  input  logic             leave,
  output logic [PIX_W-1:0] pixel,
  output logic             strobe
);

  localparam int DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  logic [DIV_W-1:0] div_q;
  logic [PIX_W-1:0] pix_q;

  // Divider and pixel index; leaving ACTIVE wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || !active || leave) begin
      div_q <= '0;
      pix_q <= '0;
    end else if (advance) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (pix_q != PIX_MAX) pix_q <= pix_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign pixel  = pix_q;
  assign strobe = active && advance && (div_q == '0);

endmodule

// File: rtl/sync_timer.sv
// One axis of a display timing generator: OFF -> PULSE -> BACK -> ACTIVE ->
// FRONT -> PULSE ... with each state lasting a fixed number of advance ticks.
// Cascade a vertical instance by feeding it the horizontal period_end.
module sync_timer
  import vga_timing_pkg::*;
#(
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int BACK_CYCLES     = DEF_BACK_CYCLES,
  parameter int ACTIVE_CYCLES   = DEF_ACTIVE_CYCLES,
  parameter int FRONT_CYCLES    = DEF_FRONT_CYCLES,
  parameter int PIXEL_DIV       = DEF_PIXEL_DIV,
  parameter int PIX_W           = 7,
  parameter int CNT_W           = 13,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic             sync,
  output logic             display_active,
  output logic [PIX_W-1:0] pixel,
  output logic             pixel_strobe,
  output logic             period_end
);

  // Parameter sanity: bad lengths would silently produce a broken period.
  if (PULSE_CYCLES < 1 || BACK_CYCLES < 1 || ACTIVE_CYCLES < 1 ||
      FRONT_CYCLES < 1 || PIXEL_DIV < 1) begin : g_bad_len
    $error("sync_timer: every length and PIXEL_DIV must be at least 1");
  end
  if ((PULSE_CYCLES - 1) >= (1 << CNT_W) || (BACK_CYCLES - 1) >= (1 << CNT_W) ||
      (ACTIVE_CYCLES - 1) >= (1 << CNT_W) || (FRONT_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("sync_timer: a state length minus 1 does not fit in CNT_W bits");
  end
  if (PIXEL_DIV >= 1 && (ACTIVE_CYCLES % PIXEL_DIV) != 0) begin : g_bad_div
    $error("sync_timer: ACTIVE_CYCLES must be a multiple of PIXEL_DIV");
  end

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last;
  logic             step_end;
  logic             in_active;
  logic [PIX_W-1:0] pix_raw;
  logic             strobe_raw;

  // Final counter value of the current state.
  function automatic logic [CNT_W-1:0] last_cnt(input timer_state_t s);
    case (s)
      ST_PULSE:  return CNT_W'(PULSE_CYCLES - 1);
      ST_BACK:   return CNT_W'(BACK_CYCLES - 1);
      ST_ACTIVE: return CNT_W'(ACTIVE_CYCLES - 1);
      ST_FRONT:  return CNT_W'(FRONT_CYCLES - 1);
      default:   return '0;
    endcase
  endfunction

  assign cnt_last  = (cnt_q == last_cnt(state_q));
  assign step_end  = advance && cnt_last && (state_q != ST_OFF);
  assign in_active = (state_q == ST_ACTIVE);

  // State register and state counter; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter: OFF is a single-clock stop regardless of advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF:    state_d = ST_PULSE;
      ST_PULSE:  if (step_end) state_d = ST_BACK;
      ST_BACK:   if (step_end) state_d = ST_ACTIVE;
      ST_ACTIVE: if (step_end) state_d = ST_FRONT;
      ST_FRONT:  if (step_end) state_d = ST_PULSE;
      default:   state_d = ST_OFF;
    endcase
    if (state_q == ST_OFF)  cnt_d = '0;
    else if (step_end)      cnt_d = '0;
    else if (advance)       cnt_d = cnt_q + 1'b1;
  end

  pixel_divider #(
    .PIXEL_DIV (PIXEL_DIV),
    .PIX_W     (PIX_W)
  ) u_pixel_divider (
    .clk     (clk),
    .reset   (reset),
    .active  (in_active),
    .advance (advance),
    .leave   (in_active && step_end),
    .pixel   (pix_raw),
    .strobe  (strobe_raw)
  );

  // Decoded outputs; held inactive while reset is high so nothing leaks out.
  always_comb begin
    sync           = sync_level(!reset && (state_q == ST_PULSE), SYNC_ACTIVE_LOW);
    display_active = !reset && in_active;
    pixel          = reset ? '0 : pix_raw;
    pixel_strobe   = !reset && strobe_raw;
    period_end     = !reset && (state_q == ST_FRONT) && advance && cnt_last;
  end

endmodule

// File: tb/tb_sync_timer.sv
// Bench for sync_timer: three instances share stimulus (ACTIVE=8 low sync,
// ACTIVE=12 low sync, ACTIVE=8 high sync). Expected outputs are queued when
// stimulus is driven and checked by a monitor on the falling edge.
module tb_sync_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic adv = 1'b0;

  always #5 clk = ~clk;

  logic       s0, d0, t0, e0, s1, d1, t1, e1, s2, d2, t2, e2;
  logic [1:0] p0, p1, p2;

  sync_timer #(.PULSE_CYCLES(4), .BACK_CYCLES(2), .ACTIVE_CYCLES(8), .FRONT_CYCLES(2),
    .PIXEL_DIV(2), .PIX_W(2), .CNT_W(4), .SYNC_ACTIVE_LOW(1'b1)) u_dut0 (
    .clk(clk), .reset(rst), .advance(adv), .sync(s0), .display_active(d0),
    .pixel(p0), .pixel_strobe(t0), .period_end(e0));

  sync_timer #(.PULSE_CYCLES(4), .BACK_CYCLES(2), .ACTIVE_CYCLES(12), .FRONT_CYCLES(2),
    .PIXEL_DIV(2), .PIX_W(2), .CNT_W(4), .SYNC_ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .reset(rst), .advance(adv), .sync(s1), .display_active(d1),
    .pixel(p1), .pixel_strobe(t1), .period_end(e1));

  sync_timer #(.PULSE_CYCLES(4), .BACK_CYCLES(2), .ACTIVE_CYCLES(8), .FRONT_CYCLES(2),
    .PIXEL_DIV(2), .PIX_W(2), .CNT_W(4), .SYNC_ACTIVE_LOW(1'b0)) u_dut2 (
    .clk(clk), .reset(rst), .advance(adv), .sync(s2), .display_active(d2),
    .pixel(p2), .pixel_strobe(t2), .period_end(e2));

  logic [2:0][5:0] got;
  assign got[0] = {s0, d0, p0, t0, e0};
  assign got[1] = {s1, d1, p1, t1, e1};
  assign got[2] = {s2, d2, p2, t2, e2};

  typedef struct {
    logic [2:0][5:0] exp;
    int              cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit         r;
    bit         a;
    logic [5:0] exp;   // {sync, display_active, pixel, strobe, period_end}
  } vec_t;
  vec_t tbl[19];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: per-instance position in advance ticks, plus an OFF flag.
  bit off_m[3];
  int t_m[3];
  int act_m[3] = '{8, 12, 8};
  bit low_m[3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic [5:0] model_out(bit r, bit off, int t, bit a, int act, bit low);
    bit s_as, da, st, pe;
    int pix, per;
    logic [1:0] pv;
    per  = 4 + 2 + act + 2;
    s_as = 1'b0; da = 1'b0; st = 1'b0; pe = 1'b0; pix = 0;
    if (!r && !off) begin
      s_as = (t < 4);
      da   = (t >= 6) && (t < 6 + act);
      if (da) pix = ((t - 6) / 2 > 3) ? 3 : (t - 6) / 2;
      st   = a && da && (((t - 6) % 2) == 0);
      pe   = a && (t == per - 1);
    end
    pv = 2'(pix);
    return {(low ? !s_as : s_as), da, pv, st, pe};
  endfunction

  task automatic step(input bit r, input bit a, input bit use_tbl, input logic [5:0] tv);
    sb_t e;
    @(posedge clk);
    #1;
    rst = r;
    adv = a;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      e.exp[k] = model_out(r, off_m[k], t_m[k], a, act_m[k], low_m[k]);
      if (r) begin
        off_m[k] = 1'b1; t_m[k] = 0;
      end else if (off_m[k]) begin
        off_m[k] = 1'b0; t_m[k] = 0;
      end else if (a) begin
        t_m[k] = (t_m[k] + 1) % (act_m[k] + 8);
      end
    end
    if (use_tbl) e.exp[0] = tv;
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (got[k] !== e.exp[k]) begin
            n_bad++;
            $display("FAIL outputs dut%0d cyc%0d: got %b expected %b (sync,da,pix,stb,pend)",
                     k, e.cyc, got[k], e.exp[k]);
          end
        end
      end
    end
  end

  task automatic fill(input int i, input bit r, input bit a, input logic [5:0] x);
    tbl[i].r = r; tbl[i].a = a; tbl[i].exp = x;
  endtask

  initial begin
    int pe_at[$];
    bit hit;

    // Hand-written waveform of the ACTIVE=8, active-low instance.
    fill(0,  1, 1, 6'b1_0_00_0_0);  // reset
    fill(1,  0, 1, 6'b1_0_00_0_0);  // OFF
    fill(2,  0, 1, 6'b0_0_00_0_0);  // PULSE x4
    fill(3,  0, 1, 6'b0_0_00_0_0);
    fill(4,  0, 1, 6'b0_0_00_0_0);
    fill(5,  0, 1, 6'b0_0_00_0_0);
    fill(6,  0, 1, 6'b1_0_00_0_0);  // BACK x2
    fill(7,  0, 1, 6'b1_0_00_0_0);
    fill(8,  0, 1, 6'b1_1_00_1_0);  // ACTIVE x8
    fill(9,  0, 1, 6'b1_1_00_0_0);
    fill(10, 0, 1, 6'b1_1_01_1_0);
    fill(11, 0, 1, 6'b1_1_01_0_0);
    fill(12, 0, 1, 6'b1_1_10_1_0);
    fill(13, 0, 1, 6'b1_1_10_0_0);
    fill(14, 0, 1, 6'b1_1_11_1_0);
    fill(15, 0, 1, 6'b1_1_11_0_0);
    fill(16, 0, 1, 6'b1_0_00_0_0);  // FRONT x2
    fill(17, 0, 1, 6'b1_0_00_0_1);
    fill(18, 0, 1, 6'b0_0_00_0_0);  // next PULSE

    for (int k = 0; k < 3; k++) begin
      off_m[k] = 1'b1; t_m[k] = 0;
    end

    for (int i = 0; i < 19; i++) step(tbl[i].r, tbl[i].a, 1'b1, tbl[i].exp);

    // Free run a few more periods with advance high (covers ACTIVE=12 too).
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 1'b0, 6'b0);

    // Reset mid-period while pixel==2, then a full restart.
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1'b0, 1'b1, 1'b0, 6'b0);
      if (p0 == 2'd2) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reach_pixel2: got timeout expected pixel 2 within 40 clocks");
    end
    step(1'b1, 1'b1, 1'b0, 6'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 6'b0);

    // Alternating advance: period doubles to 32 clocks.
    for (int i = 0; i < 90; i++) begin
      step(1'b0, (i % 2) == 0, 1'b0, 6'b0);
      if (e0) pe_at.push_back(cyc);
    end
    n_cmp++;
    if (pe_at.size() < 2) begin
      n_bad++;
      $display("FAIL alt_period: got %0d period_end pulses expected at least 2", pe_at.size());
    end else if (pe_at[1] - pe_at[0] != 32) begin
      n_bad++;
      $display("FAIL alt_period: got %0d clocks expected 32", pe_at[1] - pe_at[0]);
    end

    // Hold reset a few clocks: everything inactive, sync polarity respected.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 6'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 6'b0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_timer.md
SYNC_TIMER -- requirements
Module: sync_timer

Interface
REQ-001 Parameter PULSE_CYCLES, default 384, sync pulse length in advance ticks.
REQ-002 Parameter BACK_CYCLES, default 192, back porch length in advance ticks.
REQ-003 Parameter ACTIVE_CYCLES, default 2560, display-active length in advance ticks.
REQ-004 Parameter FRONT_CYCLES, default 64, front porch length in advance ticks.
REQ-005 Parameter PIXEL_DIV, default 20, advance ticks per pixel.
REQ-006 Parameter PIX_W, default 7, pixel index width.
REQ-007 Parameter CNT_W, default 13, state counter width.
REQ-008 Parameter SYNC_ACTIVE_LOW, default 1, 1 = sync asserted low, 0 = asserted high.
REQ-009 clk  input  1  single clock, all logic on rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 advance  input  1  count enable: 1 for a horizontal timer; a line-end strobe for a vertical timer.
REQ-012 sync  output  1  sync pulse at SYNC_ACTIVE_LOW polarity.
REQ-013 display_active  output  1  high during ACTIVE state.
REQ-014 pixel  output  PIX_W  pixel index within ACTIVE, 0 otherwise.
REQ-015 pixel_strobe  output  1  one-clock pulse on the first tick of each pixel.
REQ-016 period_end  output  1  one-clock pulse on the final tick of each period, for cascading.

Function
REQ-017 States OFF, PULSE, BACK, ACTIVE, FRONT; state register updated each clk.
REQ-018 OFF lasts exactly one clock regardless of advance, then PULSE; state counter held at 0 in OFF.
REQ-019 State counter increments only on clocks with advance=1; holds otherwise.
REQ-020 PULSE->BACK, BACK->ACTIVE, ACTIVE->FRONT, FRONT->PULSE when advance=1 and counter equals that state's length minus 1; counter clears to 0 on every transition.
REQ-021 With advance tied high each state lasts exactly its parameter in clocks; period = PULSE+BACK+ACTIVE+FRONT clocks.
REQ-022 sync at asserted level only in PULSE; inactive level in OFF, BACK, ACTIVE, FRONT.
REQ-023 sync, display_active, pixel_strobe and period_end are decoded from state, counters and advance (Moore outputs plus advance qualification), no extra latency.
REQ-024 Divider counter counts advance ticks 0..PIXEL_DIV-1 in ACTIVE only; at PIXEL_DIV-1 with advance it clears and pixel increments.
REQ-025 pixel saturates at 2^PIX_W-1; no wrap to 0 inside ACTIVE.
REQ-026 On leaving ACTIVE, pixel and divider counter clear to 0; clear has priority over the simultaneous increment.
REQ-027 pixel_strobe = ACTIVE and advance and divider counter = 0.
REQ-028 period_end = FRONT and advance and counter = FRONT_CYCLES-1.
REQ-029 All lengths are at least 1, each length minus 1 fits in CNT_W bits, and ACTIVE_CYCLES is a multiple of PIXEL_DIV; violations are flagged by an elaboration-time check.

Reset
REQ-030 reset=1 at a clk edge forces state OFF and all counters and pixel to 0, with priority over advance and all transitions.
REQ-031 Output values during and after reset: sync inactive, display_active 0, pixel 0, pixel_strobe 0, period_end 0.
REQ-032 Reset asserted mid-period aborts the period; after release the sequence restarts at OFF->PULSE.

Structure
REQ-033 State encoding and default timing constants (384/192/2560/64/20) live in a shared package vga_timing_pkg, for reuse by the vertical instance.
REQ-034 The pixel divider and saturating index are one sub-module, pixel_divider; the state machine and state counter stay in sync_timer.

Verification (bench parameters PULSE=4, BACK=2, ACTIVE=8, FRONT=2, DIV=2, PIX_W=2 unless stated)
REQ-035 Release reset, advance=1 -> one OFF clock; sync low 4 clocks, high 12; period 16 clocks, repeating.
REQ-036 Same stimulus -> display_active high 8 clocks; pixel 0,0,1,1,2,2,3,3; pixel_strobe on clocks 1,3,5,7 of ACTIVE; period_end on the last FRONT clock.
REQ-037 advance alternating 1/0 -> period 32 clocks; period_end single-clock, coincident with advance=1.
REQ-038 ACTIVE=12 -> pixel 0,0,1,1,2,2,3,3,3,3,3,3, then 0 in FRONT.
REQ-039 reset pulsed while pixel=2 -> next clock state OFF, pixel 0, display_active 0, sync inactive; full 16-clock period follows.
REQ-040 SYNC_ACTIVE_LOW=0 -> sync high for 4 clocks per period, low otherwise and during reset.
